// File: rtl/gate_sweep_ctrl.sv
// Exhaustive operand sweep engine for two gate implementations of one function.
// Holds each (a, b) vector for SETTLE cycles, checks both results against a golden model.
module gate_sweep_ctrl #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] res1,
    input  logic [WIDTH-1:0] res2,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE - 1);
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    logic [1:0]         op_lat;
    logic [SC_W-1:0]    scnt;
    logic [WIDTH-1:0]   golden_val;
    logic               vec_fail;
    logic               last_vec;
    logic [2*WIDTH-1:0] ab_next;

    function automatic logic [WIDTH-1:0] golden(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_NOT:  r = ~x;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // A vector counts once even when both implementations disagree with the golden value.
    assign golden_val = golden(op_lat, a, b);
    assign vec_fail   = (res1 != golden_val) || (res2 != golden_val);
    assign last_vec   = &{a, b};
    assign ab_next    = {a, b} + (2*WIDTH)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_lat     <= 2'b00;
            scnt       <= '0;
            a          <= '0;
            b          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_lat     <= op;
                        a          <= '0;
                        b          <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        pass       <= 1'b0;
                        scnt       <= SC_LOAD;
                        busy       <= 1'b1;
                        state      <= (op == OP_RSV) ? S_DONE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (scnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        scnt <= scnt - SC_W'(1);
                    end
                end
                S_CHECK: begin
                    if (vec_fail) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= a;
                            fail_b     <= b;
                        end
                    end
                    if (last_vec) begin
                        state <= S_DONE;
                    end else begin
                        {a, b} <= ab_next;
                        scnt   <= SC_LOAD;
                        state  <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (op_lat != OP_RSV) && (err_cnt == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
